// File: rtl/vxe_fifo_unpack.sv
// vxe_fifo_unpack: serializes each wide word popped from an upstream FIFO
// into 2^RATIO_POW2 narrow beats, least-significant beat first, with a
// valid/ready handshake on the narrow side and no idle cycle between words.
module vxe_fifo_unpack #(
    parameter int OUT_WIDTH  = 32,
    parameter int RATIO_POW2 = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [OUT_WIDTH*(2**RATIO_POW2)-1:0]    fifo_data,
    input  logic                                    fifo_vld,
    output logic                                    fifo_rd,
    output logic [OUT_WIDTH-1:0]                    out_data,
    output logic                                    out_vld,
    input  logic                                    out_rdy,
    output logic                                    out_last
);

    localparam int N  = 2 ** RATIO_POW2;
    // A zero-width index is not legal, so the N=1 case keeps a 1-bit index tied to 0.
    localparam int BW = (RATIO_POW2 == 0) ? 1 : RATIO_POW2;
    localparam logic [BW-1:0] LAST_IDX = BW'(N - 1);

    logic [OUT_WIDTH*N-1:0] hold_q;
    logic                   hold_vld_q, hold_vld_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic                   last_beat;
    logic                   xfer;

    assign last_beat = (beat_q == LAST_IDX);

    // Pop when the holding register is empty, or when its final beat leaves this
    // cycle so the next word is loaded without a bubble. Reset masks the strobe.
    assign fifo_rd  = !rst && fifo_vld && (!hold_vld_q || (out_rdy && last_beat));
    assign out_vld  = !rst && hold_vld_q;
    assign out_last = out_vld && last_beat;
    assign xfer     = out_vld && out_rdy;
    assign out_data = hold_q[int'(beat_q)*OUT_WIDTH +: OUT_WIDTH];

    // Next-state for the valid flag and beat index; a pop takes priority over the wrap.
    always_comb begin
        hold_vld_d = hold_vld_q;
        beat_d     = beat_q;
        if (fifo_rd) begin
            hold_vld_d = 1'b1;
            beat_d     = '0;
        end else if (xfer) begin
            if (last_beat) begin
                hold_vld_d = 1'b0;
                beat_d     = '0;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
    end

    // Control state register; reset drops any partially sent word.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld_q <= 1'b0;
            beat_q     <= '0;
        end else begin
            hold_vld_q <= hold_vld_d;
            beat_q     <= beat_d;
        end
    end

    // Data holding register; captures the FIFO head on every pop, no reset needed.
    always_ff @(posedge clk) begin
        if (fifo_rd) begin
            hold_q <= fifo_data;
        end
    end

endmodule

// File: tb/tb_vxe_fifo_unpack.sv
// Testbench for vxe_fifo_unpack (OUT_WIDTH=8, RATIO_POW2=2): directed scenarios
// plus a randomized run, with a scoreboard queue of expected beats and a
// separate monitor that consumes it on every output transfer.
module tb_vxe_fifo_unpack;

    localparam int OW = 8;
    localparam int RP = 2;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [OW*N-1:0] fifo_data;
    logic            fifo_vld;
    logic            fifo_rd;
    logic [OW-1:0]   out_data;
    logic            out_vld;
    logic            out_rdy;
    logic            out_last;

    vxe_fifo_unpack #(.OUT_WIDTH(OW), .RATIO_POW2(RP)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_data (fifo_data),
        .fifo_vld  (fifo_vld),
        .fifo_rd   (fifo_rd),
        .out_data  (out_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [OW*N-1:0] wq[$];     // upstream FIFO model contents
    logic [OW:0]     exp_q[$];  // expected beats {last, data}
    logic            vld_en;
    logic            pop_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_vld  = vld_en && (wq.size() > 0);
        fifo_data = (wq.size() > 0) ? wq[0] : '0;
    endtask

    task automatic push_word(input logic [OW*N-1:0] w);
        wq.push_back(w);
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({(i == N - 1), w[i*OW +: OW]});
        end
        drive_fifo();
    endtask

    // Advance one cycle; apply the pop the monitor saw in the cycle just ended.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_pending) begin
            if (wq.size() > 0) void'(wq.pop_front());
            pop_pending = 1'b0;
        end
        drive_fifo();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        out_rdy = 1'b1;
        vld_en  = 1'b1;
        drive_fifo();
        while ((exp_q.size() > 0 || out_vld) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d beats outstanding expected 0", exp_q.size());
        end
        tick();
    endtask

    // Monitor: scoreboard compare on each transfer, protocol check on fifo_rd.
    initial begin
        logic [OW:0] e;
        forever begin
            @(negedge clk);
            if (fifo_rd && !fifo_vld) begin
                chk("rd_without_vld", {31'd0, fifo_rd}, 32'd0);
            end
            if (fifo_rd) pop_pending = 1'b1;
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {23'd0, out_last, out_data}, 32'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_beat", {23'd0, out_last, out_data}, {23'd0, e});
                end
            end
        end
    end

    logic [OW-1:0] seq8 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    initial begin
        rst     = 1'b1;
        out_rdy = 1'b1;
        vld_en  = 1'b1;
        drive_fifo();

        // Reset with a word waiting: no pop, no output.
        push_word(32'hDDCCBBAA);
        tick();
        @(negedge clk);
        chk("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rd", {31'd0, fifo_rd}, 32'd1);
        tick();
        drain(20);

        // Single word, full throughput.
        push_word(32'h44332211);
        @(negedge clk);
        chk("single_rd", {31'd0, fifo_rd}, 32'd1);
        for (int i = 0; i < N; i++) begin
            tick();
            @(negedge clk);
            chk("single_vld", {31'd0, out_vld}, 32'd1);
            chk("single_data", {24'd0, out_data}, {24'd0, seq8[i]});
            chk("single_last", {31'd0, out_last}, {31'd0, (i == N - 1)});
            chk("single_norepop", {31'd0, fifo_rd}, 32'd0);
        end
        tick();
        @(negedge clk);
        chk("single_idle", {31'd0, out_vld}, 32'd0);
        drain(10);

        // Back-to-back words: reload coincides with the last beat.
        push_word(32'h44332211);
        push_word(32'h88776655);
        for (int i = 0; i < 2 * N; i++) begin
            tick();
            @(negedge clk);
            chk("b2b_data", {24'd0, out_data}, {24'd0, seq8[i]});
            chk("b2b_vld", {31'd0, out_vld}, 32'd1);
            if (i == N - 1) chk("b2b_rd_on_last", {31'd0, fifo_rd}, 32'd1);
        end
        tick();
        @(negedge clk);
        chk("b2b_idle", {31'd0, out_vld}, 32'd0);
        drain(10);

        // Backpressure while 0x22 is presented, with a word waiting upstream.
        push_word(32'h44332211);
        tick();                      // 0x11 presented and taken
        push_word(32'h88776655);
        tick();
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_data", {24'd0, out_data}, 32'h22);
            chk("bp_vld", {31'd0, out_vld}, 32'd1);
            chk("bp_rd", {31'd0, fifo_rd}, 32'd0);
            tick();
            out_rdy = (i == 2);
        end
        @(negedge clk);
        chk("bp_resume", {24'd0, out_data}, 32'h22);
        drain(20);

        // Upstream empty after the first word, then a later word.
        push_word(32'h44332211);
        for (int i = 0; i < N; i++) tick();
        @(negedge clk);
        chk("empty_last", {24'd0, out_data}, 32'h44);
        tick();
        @(negedge clk);
        chk("empty_drop", {31'd0, out_vld}, 32'd0);
        tick();
        push_word(32'h88776655);
        @(negedge clk);
        chk("empty_late_rd", {31'd0, fifo_rd}, 32'd1);
        tick();
        @(negedge clk);
        chk("empty_late_beat", {24'd0, out_data}, 32'h55);
        chk("empty_late_vld", {31'd0, out_vld}, 32'd1);
        drain(20);

        // Reset after 0x22 leaves: 0x33/0x44 are discarded.
        push_word(32'h44332211);
        push_word(32'h88776655);
        tick();
        tick();
        tick();
        void'(exp_q.pop_front());    // 0x33 never emitted
        void'(exp_q.pop_front());    // 0x44 never emitted
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_vld", {31'd0, out_vld}, 32'd0);
        chk("midrst_rd", {31'd0, fifo_rd}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_resume_rd", {31'd0, fifo_rd}, 32'd1);
        tick();
        @(negedge clk);
        chk("midrst_beat0", {24'd0, out_data}, 32'h55);
        drain(20);

        // Random upstream availability and downstream backpressure.
        for (int i = 0; i < 30; i++) push_word($urandom());
        for (int c = 0; c < 1500 && exp_q.size() > 0; c++) begin
            vld_en  = ($urandom_range(0, 3) != 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            drive_fifo();
            tick();
        end
        drain(200);
        chk("wq_empty", wq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
